// File: rtl/ram_image_arb_pkg.sv
// ram_image_arb_pkg: shared types and default widths for the image RAM arbiter
package ram_image_arb_pkg;
  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {P0_PRI, P1_FORCE, P1_LOCK} arb_state_t;
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_id_t;
endpackage

// File: rtl/ram_image_arb_rsp.sv
// ram_image_arb_rsp: read-return stage, tags each granted read and raises the owner's rvalid one cycle later
// Ports: clock/reset_n; rd_en + rd_tag mark a granted read this cycle; ram_q is the RAM output;
// p0_/p1_rvalid and p0_/p1_rdata return the data to the port that issued the read.
module ram_image_arb_rsp
  import ram_image_arb_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rd_en,
  input  port_id_t           rd_tag,
  input  logic [D_WIDTH-1:0] ram_q,
  output logic               p0_rvalid,
  output logic               p1_rvalid,
  output logic [D_WIDTH-1:0] p0_rdata,
  output logic [D_WIDTH-1:0] p1_rdata
);
  logic     vld_q, vld_d;
  port_id_t tag_q, tag_d;
  always_comb begin
    vld_d = rd_en;
    tag_d = rd_en ? rd_tag : tag_q;
  end
  // reset clears the valid flag so an in-flight read is never returned
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      tag_q <= PORT0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end
  assign p0_rvalid = vld_q && (tag_q == PORT0);
  assign p1_rvalid = vld_q && (tag_q == PORT1);
  assign p0_rdata  = ram_q;
  assign p1_rdata  = ram_q;
endmodule

// File: rtl/ram_image_arbiter.sv
// ram_image_arbiter: shares one single-port image RAM between a priority display reader (p0) and an engine (p1)
// Ports: p0_* display read port; p1_* engine read/write port with lock; ram_* drive/return of the RAM.
// Optional: define RAM_IMAGE_ARB_STATS_EN to add stat_p0_grants/stat_p1_grants/stat_conflicts counters.
module ram_image_arbiter
  import ram_image_arb_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int A_WIDTH    = A_WIDTH_DEF,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               p0_req,
  input  logic [A_WIDTH-1:0] p0_addr,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [D_WIDTH-1:0] p0_rdata,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic               p1_lock,
  input  logic [A_WIDTH-1:0] p1_addr,
  input  logic [D_WIDTH-1:0] p1_wdata,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [D_WIDTH-1:0] p1_rdata,
  output logic               ram_wren,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [D_WIDTH-1:0] ram_data,
  input  logic [D_WIDTH-1:0] ram_q
`ifdef RAM_IMAGE_ARB_STATS_EN
  ,
  output logic [31:0]        stat_p0_grants,
  output logic [31:0]        stat_p1_grants,
  output logic [31:0]        stat_conflicts
`endif
);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] LOCK_TOP   = CNT_W'(LOCK_MAX - 1);
  localparam bit               LOCK_EN    = LOCK_MAX > 1;
  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             p1_denied, starve_hit, lock_go;
  // p1 wins outright in FORCE/LOCK; otherwise only when p0 is idle
  always_comb begin
    p1_gnt       = reset_n && p1_req && ((state_q != P0_PRI) || !p0_req);
    p0_gnt       = reset_n && p0_req && !p1_gnt;
    p1_denied    = p1_req && !p1_gnt;
    starve_hit   = p1_denied && (starve_cnt_q == STARVE_TOP);
    lock_go      = p1_gnt && p1_lock && LOCK_EN;
    state_d      = (state_q == P0_PRI && starve_hit) ? P1_FORCE :
                   (lock_go && (state_q != P1_LOCK || lock_cnt_q != LOCK_TOP)) ? P1_LOCK : P0_PRI;
    starve_cnt_d = p1_denied ? (starve_hit ? starve_cnt_q : starve_cnt_q + 1'b1) : '0;
    // the grant that enters the lock counts toward LOCK_MAX consecutive grants
    lock_cnt_d   = (state_d == P1_LOCK) ? lock_cnt_q + 1'b1 : '0;
    ram_addr     = p1_gnt ? p1_addr : p0_addr;
    ram_data     = p1_gnt ? p1_wdata : '0;
    ram_wren     = p1_gnt && p1_we;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= P0_PRI;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
  ram_image_arb_rsp #(.D_WIDTH(D_WIDTH)) u_rsp (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_en    (p0_gnt || (p1_gnt && !p1_we)),
    .rd_tag   (p1_gnt ? PORT1 : PORT0),
    .ram_q    (ram_q),
    .p0_rvalid(p0_rvalid),
    .p1_rvalid(p1_rvalid),
    .p0_rdata (p0_rdata),
    .p1_rdata (p1_rdata)
  );
`ifdef RAM_IMAGE_ARB_STATS_EN
  logic [31:0] st_p0_q, st_p0_d, st_p1_q, st_p1_d, st_cf_q, st_cf_d;
  always_comb begin
    st_p0_d = st_p0_q + 32'(p0_gnt);
    st_p1_d = st_p1_q + 32'(p1_gnt);
    st_cf_d = st_cf_q + 32'(p0_req && p1_req);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_p0_q <= '0;
      st_p1_q <= '0;
      st_cf_q <= '0;
    end else begin
      st_p0_q <= st_p0_d;
      st_p1_q <= st_p1_d;
      st_cf_q <= st_cf_d;
    end
  end
  assign stat_p0_grants = st_p0_q;
  assign stat_p1_grants = st_p1_q;
  assign stat_conflicts = st_cf_q;
`endif
endmodule

// File: tb/tb_ram_image_arbiter.sv
// tb_ram_image_arbiter: directed scoreboard bench for ram_image_arbiter with a behavioural image RAM
module tb_ram_image_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [7:0] p1_wdata = '0;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_wren;
  logic [7:0] p0_rdata, p1_rdata, ram_data, ram_q;
  logic [15:0] ram_addr;
`ifdef RAM_IMAGE_ARB_STATS_EN
  logic [31:0] stat_p0_grants, stat_p1_grants, stat_conflicts;
`endif
  int checks = 0, fails = 0;
  int p0_left = 0, p1_left = 0;
  logic pend0 = 1'b0, pend1 = 1'b0, g0 = 1'b0, g1 = 1'b0;
  logic [7:0] q0[$], q1[$];
  logic [7:0] shadow[logic [15:0]];
  logic [7:0] tmp;
  logic [7:0] mem[0:65535];
  logic [15:0] raddr_q = '0;
  logic pre = 1'b0;

  always #5 clk = ~clk;

  ram_image_arbiter dut (
    .clock(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
`ifdef RAM_IMAGE_ARB_STATS_EN
    , .stat_p0_grants(stat_p0_grants), .stat_p1_grants(stat_p1_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a < 16'd4) ? 8'h10 + a[7:0] : a[7:0] * 8'd7 + 8'd3;
  endfunction

  function automatic logic [7:0] expval(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (!pre) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      pre <= 1'b1;
    end else if (ram_wren) mem[ram_addr] <= ram_data;
    raddr_q <= ram_addr;
  end
  assign ram_q = mem[raddr_q];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue0(input logic [15:0] a);
    p0_req = 1'b1; p0_addr = a; q0.push_back(expval(a));
  endtask

  task automatic issue1(input logic [15:0] a);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = a; p1_wdata = '0; q1.push_back(expval(a));
  endtask

  task automatic issue_wr(input logic [15:0] a, input logic [7:0] d);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = a; p1_wdata = d; shadow[a] = d;
  endtask

  task automatic drop0();
    if (p0_req) begin p0_req = 1'b0; tmp = q0.pop_back(); end
  endtask

  task automatic drop1();
    if (p1_req) begin p1_req = 1'b0; p1_we = 1'b0; if (!p1_we) tmp = q1.pop_back(); end
  endtask

  task automatic look(input logic e0, input logic e1);
    @(negedge clk);
    chk("p0_rvalid", p0_rvalid, pend0);
    chk("p1_rvalid", p1_rvalid, pend1);
    if (p0_rvalid === 1'b1) begin
      chk("p0_rsp_expected", q0.size() > 0, 1);
      if (q0.size() > 0) chk("p0_rdata", p0_rdata, q0.pop_front());
    end
    if (p1_rvalid === 1'b1) begin
      chk("p1_rsp_expected", q1.size() > 0, 1);
      if (q1.size() > 0) chk("p1_rdata", p1_rdata, q1.pop_front());
    end
    chk("p0_gnt", p0_gnt, e0);
    chk("p1_gnt", p1_gnt, e1);
    g0 = p0_gnt === 1'b1;
    g1 = p1_gnt === 1'b1;
    pend0 = e0;
    pend1 = e1 && !p1_we;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (g0) begin
      if (p0_left > 0) begin p0_left--; issue0(p0_addr + 16'd1); end else p0_req = 1'b0;
    end
    if (g1) begin
      if (p1_left > 0) begin p1_left--; issue1(p1_addr + 16'd1); end
      else begin p1_req = 1'b0; p1_we = 1'b0; end
    end
  endtask

  task automatic run(input int from, input int to, input logic [9:0] pat);
    for (int i = from; i < to; i++) begin
      look(!pat[i], pat[i]);
      step();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    look(1'b0, 1'b0);
    chk("ram_wren_idle", ram_wren, 0);
    step();
    // both held: four p0 grants then a forced p1 grant, repeating
    issue0(16'h0100); p0_left = 50;
    issue1(16'h0200); p1_left = 50;
    run(0, 10, 10'b1000010000);
`ifdef RAM_IMAGE_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 10);
    chk("stat_p0_grants", stat_p0_grants, 8);
    chk("stat_p1_grants", stat_p1_grants, 2);
`endif
    drop0(); drop1();
    look(1'b0, 1'b0);
    step();
    // p0 only, addresses 0..3 hold 0x10..0x13
    issue0(16'h0000); p0_left = 3;
    run(0, 4, 10'b0);
    look(1'b0, 1'b0);
    step();
    // write then read-after-write on p1
    issue_wr(16'h1234, 8'hAB); p1_left = 0;
    look(1'b0, 1'b1);
    chk("wr_ram_wren", ram_wren, 1);
    chk("wr_ram_addr", ram_addr, 16'h1234);
    chk("wr_ram_data", ram_data, 8'hAB);
    step();
    issue1(16'h1234);
    look(1'b0, 1'b1);
    chk("rd_ram_wren", ram_wren, 0);
    chk("rd_ram_addr", ram_addr, 16'h1234);
    step();
    look(1'b0, 1'b0);
    chk("idle_ram_addr", ram_addr, p0_addr);
    chk("idle_ram_data", ram_data, 0);
    chk("idle_ram_wren", ram_wren, 0);
    step();
    // lock: p1 holds four grants, p0 waits, then starvation forces p1 back in
    p1_lock = 1'b1;
    issue1(16'h0300); p1_left = 5;
    look(1'b0, 1'b1);
    step();
    issue0(16'h0400); p0_left = 50;
    run(1, 10, 10'b1100001111);
    p1_lock = 1'b0;
    drop0(); drop1();
    look(1'b0, 1'b0);
    step();
    // reset right after a p0 grant drops its read return
    issue0(16'h0005); p0_left = 0;
    look(1'b1, 1'b0);
    reset_n = 1'b0;
    q0.delete();
    pend0 = 1'b0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0007; p1_wdata = 8'hEE;
    @(posedge clk); #1;
    look(1'b0, 1'b0);
    chk("rst_ram_wren", ram_wren, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
    look(1'b0, 1'b0);
    step();
    issue0(16'h0040); p0_left = 50;
    issue1(16'h0080); p1_left = 50;
    run(0, 5, 10'b0000010000);
    drop0(); drop1();
    look(1'b0, 1'b0);
    step();
    look(1'b0, 1'b0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ram_image_arbiter.md
Name: ram_image_arbiter

Overview:
- Shares the single-port image RAM (256x256 x 8-bit, 1-cycle registered-address read) between two requesters.
- Port 0 is the display scan-out reader: read-only, high priority.
- Port 1 is the image-processing engine: read/write, with a bounded-starvation guarantee and an optional short lock.
- Drives the RAM's wren/data/address and returns RAM q to the requester whose read was granted, with a valid strobe.

Parameters:
- D_WIDTH, 8, pixel data width.
- A_WIDTH, 16, RAM address width.
- STARVE_MAX, 4, max consecutive cycles port 1 may be denied while requesting before it is forced a grant; legal range 1..15.
- LOCK_MAX, 4, max consecutive grants port 1 may hold via p1_lock; legal range 1..15.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  display read request.
- p0_addr  in  A_WIDTH  display read address.
- p0_gnt  out  1  display request accepted this cycle.
- p0_rvalid  out  1  p0_rdata valid, one cycle after p0_gnt.
- p0_rdata  out  D_WIDTH  display read data.
- p1_req  in  1  engine request.
- p1_we  in  1  engine write (1) / read (0).
- p1_lock  in  1  engine requests to keep the grant next cycle.
- p1_addr  in  A_WIDTH  engine address.
- p1_wdata  in  D_WIDTH  engine write data.
- p1_gnt  out  1  engine request accepted this cycle; a write completes at this edge.
- p1_rvalid  out  1  p1_rdata valid, one cycle after a granted read.
- p1_rdata  out  D_WIDTH  engine read data.
- ram_wren  out  1  to RAM wren.
- ram_addr  out  A_WIDTH  to RAM address.
- ram_data  out  D_WIDTH  to RAM data.
- ram_q  in  D_WIDTH  from RAM q.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, reset_n.
- Reset: FSM=P0_PRI, starve_cnt=0, lock_cnt=0, both rvalid=0.
  - While reset_n=0: p0_gnt=p1_gnt=0, ram_wren=0.
  - Reset mid-access: a pending rvalid is dropped and never issued.
- Grants are combinational from req and registered state, issued the same cycle. At most one gnt is high per cycle.
- Requests are level-held: a requester keeps req/addr/we/wdata stable until it sees gnt.
- FSM states:
  - P0_PRI: grant p0 if p0_req; else grant p1 if p1_req.
    - Go to P1_FORCE when p1_req && !p1_gnt && starve_cnt==STARVE_MAX-1.
    - Go to P1_LOCK when p1_gnt && p1_lock && LOCK_MAX>1.
  - P1_FORCE: grant p1 if p1_req, regardless of p0_req.
    - Next is P1_LOCK if p1_gnt && p1_lock, else P0_PRI.
    - If p1_req has dropped, grant p0 if requested and return to P0_PRI.
  - P1_LOCK: grant p1 if p1_req; lock_cnt increments per lock grant.
    - Return to P0_PRI when !p1_lock, !p1_req, or lock_cnt==LOCK_MAX-1.
    - lock_cnt clears on exit.
- starve_cnt increments on each cycle with p1_req && !p1_gnt. It clears on p1_gnt or !p1_req and saturates at STARVE_MAX-1.
- RAM drive: ram_addr/ram_data/ram_wren are muxed from the granted port.
  - With no grant: ram_addr=p0_addr, ram_wren=0, ram_data=0.
  - ram_wren = p1_gnt && p1_we.
- Read return:
  - 1-bit tag registers and rvalid flags register on each granted read; p0_rvalid / p1_rvalid assert exactly one cycle after the grant.
  - p0_rdata = p1_rdata = ram_q, qualified only by rvalid.
  - No rvalid follows a granted write, even though ram_q changes.
- Read-after-write to the same address on consecutive p1 grants returns the new data.
- Back-to-back reads on alternating ports are legal at one access per cycle, full throughput.

Optional Feature:
- Macro: RAM_IMAGE_ARB_STATS_EN.
- When defined, adds three outputs, each 32 bits, wrapping modulo 2^32, reset to 0:
  - stat_p0_grants: count of p0 grants.
  - stat_p1_grants: count of p1 grants.
  - stat_conflicts: count of cycles with p0_req && p1_req.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ram_image_arb_pkg:
  - arb_state_t enum {P0_PRI, P1_FORCE, P1_LOCK}.
  - port_id_t (1 bit).
  - Default D_WIDTH/A_WIDTH constants.
- One sub-module, ram_image_arb_rsp: the read-return register stage (tag, rvalid generation, reset drop).
- FSM, counters and mux stay in the top module.

Test Plan:
- Only p0_req, addr 0x0000..0x0003 over 4 cycles, memory preloaded 0x10..0x13 -> p0_gnt every cycle; p0_rvalid with rdata 0x10,0x11,0x12,0x13 one cycle late; p1_rvalid never set.
- p0_req and p1_req held continuously, STARVE_MAX=4 -> grant pattern p0,p0,p0,p0,p1 repeating; never two gnts in one cycle.
- p1 write 0xAB to 0x1234, then p1 read 0x1234 next cycle, p0 idle -> ram_wren=1 for one cycle; p1_rvalid with rdata 0xAB; no rvalid after the write.
- p1_lock high, p1_req with 6 reads, LOCK_MAX=4, p0_req asserted meanwhile -> p1 holds 4 consecutive grants, then p0 is granted.
- reset_n pulled low the cycle after a p0 grant -> p0_rvalid stays 0; after release state is P0_PRI and starve_cnt is 0.
- With RAM_IMAGE_ARB_STATS_EN, 10 cycles of both requesting -> stat_conflicts=10, stat_p0_grants=8, stat_p1_grants=2.
